jt10_adpcm_rdarb: RTL
=====================

# jt10_adpcm_rdarb

Parametrised ROM read arbiter for the ADPCM engines of the YM2610 family. It sits between CH sample-fetch channels (ADPCM-A voices plus the ADPCM-B voice) and one shared, variable-latency ROM/SDRAM read port. It replaces the fixed multiplexed-pin fetch of the 2610 with round-robin arbitration, a per-channel last-byte cache, channel masking and a ROM timeout.

## Interface
Parameters:
- CH, 7, number of requesting channels (1..16)
- AW, 24, byte address width
- TMO, 255, cycles to wait for rom_ok before abandoning a fetch (1..1023)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- ch_enable  in  CH  per-channel enable; 0 = channel masked
- ch_req  in  CH  one-cycle request pulse per channel
- ch_addr  in  CH*AW  channel n address at bits [n*AW +: AW], held stable while the request is pending
- ch_ok  out  CH  one-cycle data-valid pulse per channel
- ch_data  out  8  byte for the channel pulsing ch_ok
- ch_ovf  out  CH  sticky: a request arrived while that channel was already pending
- rom_addr  out  AW  ROM byte address
- rom_cs  out  1  ROM read request, held until rom_ok
- rom_ok  in  1  ROM data valid, sampled only while rom_cs=1
- rom_data  in  8  ROM data
- tmo_err  out  1  sticky: a ROM fetch timed out

## Operation
- pending[n] is set on ch_req[n] and cleared when channel n is serviced. ch_req[n] while pending[n]=1 sets ch_ovf[n]. The request is merged; no second fetch occurs.
- Cache: each channel stores tag[n] (AW bits), byte[n] and valid[n]. All valid bits clear at reset.
- FSM states: IDLE, PICK, ISSUE, DONE.
  - IDLE: if any pending bit is set, go to PICK.
  - PICK: select the first pending channel at or after rr_ptr, wrapping modulo CH. Then:
    - Masked channel: service with data 8'h00 and go to DONE. No ROM access; the cache is unchanged.
    - Cache hit (valid and tag equals ch_addr): service with byte[n] and go to DONE.
    - Miss: load rom_addr, assert rom_cs and go to ISSUE.
  - ISSUE: hold rom_cs and rom_addr. On the cycle rom_ok=1:
    - Latch rom_data into ch_data and the cache (tag, byte, valid=1).
    - Drop rom_cs and go to DONE.
    - If the timeout counter reaches TMO first: ch_data=8'h00, set tmo_err, leave the cache untouched, drop rom_cs and go to DONE.
  - DONE: pulse ch_ok[n] for one cycle, clear pending[n], set rr_ptr=(n+1) mod CH and return to IDLE.
- ch_data holds its value until the next service.
- Masking a channel while its ROM fetch is in ISSUE does not abort the fetch; the fetched data is delivered.
- ch_enable[n]=0 also clears valid[n].
- ch_ovf and tmo_err clear only on reset.

## Timing
- Reset values: ch_ok=0, ch_data=0, ch_ovf=0, rom_addr=0, rom_cs=0, tmo_err=0, rr_ptr=0, all pending and valid bits = 0, FSM in IDLE. Reset mid-fetch drops rom_cs asynchronously.
- Cycle reference: ch_req at edge t, pending set at t+1, PICK at t+2.
- Hit or masked channel: ch_ok at t+3, i.e. a 3-cycle latency.
- Miss:
  - rom_cs=1 from t+3.
  - rom_ok seen at cycle u: rom_cs=0 at u+1, ch_ok at u+1.
  - Minimum miss latency is 4 cycles (rom_ok in the first ISSUE cycle).
- Timeout: rom_cs drops after exactly TMO ISSUE cycles without rom_ok; ch_ok follows on the next cycle.
- ch_req at the same edge as ch_ok for the same channel: pending is cleared and then set again. The new request is kept, and no overflow is flagged.
- rom_ok while rom_cs=0 is ignored.
- Throughput: at most one service per 3 cycles (hits). Every pending channel is served within CH services.

## Test plan
- Miss then hit:
  - ch_req[2] with address 0x001234, rom_ok 5 cycles after rom_cs, rom_data 0xA5 -> rom_addr=0x001234, ch_ok[2] with data 0xA5.
  - Repeat the same address -> ch_ok[2] at t+3 with data 0xA5 and rom_cs never asserted.
- Round-robin: pulse ch_req on channels 0, 3 and 6 together with rr_ptr=4 -> service order 6, 0, 3; rr_ptr ends at 4.
- Masking:
  - ch_enable[1]=0, ch_req[1] -> ch_ok[1] with data 0x00 at t+3, no rom_cs.
  - Re-enable and request the previously cached address -> a ROM fetch occurs.
- Timeout: TMO=8, rom_ok held low -> rom_cs high for exactly 8 cycles, then ch_ok with data 0x00 and tmo_err=1. A subsequent request to the same address misses.
- Overflow and merge: ch_req[4] twice before service -> ch_ovf[4]=1, exactly one rom_cs burst, exactly one ch_ok[4].
- Reset during ISSUE: assert rst_n=0 -> rom_cs=0 immediately. After release, all outputs are 0 and a pending request is lost (no ch_ok).

Source files
------------

// File: rtl/jt10_adpcm_rdarb.sv
// Round-robin ROM read arbiter for the ADPCM fetch channels, with a one-byte
// per-channel cache, channel masking and a ROM response timeout.
module jt10_adpcm_rdarb #(
    parameter int CH  = 7,
    parameter int AW  = 24,
    parameter int TMO = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [CH-1:0]    ch_enable,
    input  logic [CH-1:0]    ch_req,
    input  logic [CH*AW-1:0] ch_addr,
    output logic [CH-1:0]    ch_ok,
    output logic [7:0]       ch_data,
    output logic [CH-1:0]    ch_ovf,
    output logic [AW-1:0]    rom_addr,
    output logic             rom_cs,
    input  logic             rom_ok,
    input  logic [7:0]       rom_data,
    output logic             tmo_err
);

    localparam int PW = (CH > 1) ? $clog2(CH) : 1;
    localparam int TW = 10;

    typedef enum logic [1:0] {IDLE, PICK, ISSUE, DONE} state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] sel_q, sel_d;
    logic [PW-1:0] rr_ptr_q, rr_ptr_d;
    logic [CH-1:0] pending_q, pending_d;
    logic [CH-1:0] valid_q, valid_d;
    logic [CH-1:0] ch_ok_q, ch_ok_d;
    logic [7:0]    ch_data_q, ch_data_d;
    logic [CH-1:0] ch_ovf_q, ch_ovf_d;
    logic [AW-1:0] rom_addr_q, rom_addr_d;
    logic          rom_cs_q, rom_cs_d;
    logic          tmo_err_q, tmo_err_d;
    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic [AW-1:0] tag_q [CH];
    logic [7:0]    byte_q [CH];
    logic          cache_we;
    logic [CH-1:0] clr;
    logic          pick_found;
    logic [PW-1:0] pick_idx;
    logic [AW-1:0] addr_w [CH];

    for (genvar g = 0; g < CH; g++) begin : g_addr
        assign addr_w[g] = ch_addr[g*AW +: AW];
    end

    // First pending channel at or after rr_ptr, wrapping around
    always_comb begin
        int idx;
        idx        = 0;
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int i = 0; i < CH; i++) begin
            idx = int'(rr_ptr_q) + i;
            if (idx >= CH) idx = idx - CH;
            if (!pick_found && pending_q[idx]) begin
                pick_found = 1'b1;
                pick_idx   = idx[PW-1:0];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        rr_ptr_d   = rr_ptr_q;
        ch_ok_d    = '0;
        ch_data_d  = ch_data_q;
        rom_addr_d = rom_addr_q;
        rom_cs_d   = rom_cs_q;
        tmo_err_d  = tmo_err_q;
        tmo_cnt_d  = tmo_cnt_q;
        valid_d    = valid_q;
        cache_we   = 1'b0;
        clr        = '0;
        case (state_q)
            IDLE: begin
                if (|pending_q) state_d = PICK;
            end
            PICK: begin
                if (!pick_found) begin
                    state_d = IDLE;
                end else begin
                    sel_d = pick_idx;
                    if (!ch_enable[pick_idx]) begin
                        ch_data_d         = 8'h00;
                        ch_ok_d[pick_idx] = 1'b1;
                        state_d           = DONE;
                    end else if (valid_q[pick_idx] && tag_q[pick_idx] == addr_w[pick_idx]) begin
                        ch_data_d         = byte_q[pick_idx];
                        ch_ok_d[pick_idx] = 1'b1;
                        state_d           = DONE;
                    end else begin
                        rom_addr_d = addr_w[pick_idx];
                        rom_cs_d   = 1'b1;
                        tmo_cnt_d  = '0;
                        state_d    = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (rom_ok) begin
                    ch_data_d      = rom_data;
                    cache_we       = 1'b1;
                    valid_d[sel_q] = 1'b1;
                    rom_cs_d       = 1'b0;
                    ch_ok_d[sel_q] = 1'b1;
                    state_d        = DONE;
                end else if (tmo_cnt_q == TW'(TMO - 1)) begin
                    ch_data_d      = 8'h00;
                    tmo_err_d      = 1'b1;
                    rom_cs_d       = 1'b0;
                    ch_ok_d[sel_q] = 1'b1;
                    state_d        = DONE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
            end
            DONE: begin
                clr[sel_q] = 1'b1;
                rr_ptr_d   = (sel_q == PW'(CH - 1)) ? '0 : sel_q + 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // A request landing on the clearing edge re-arms the channel without overflow
        ch_ovf_d  = ch_ovf_q | (ch_req & pending_q & ~clr);
        pending_d = (pending_q & ~clr) | ch_req;
        valid_d   = valid_d & ch_enable;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            sel_q      <= '0;
            rr_ptr_q   <= '0;
            pending_q  <= '0;
            valid_q    <= '0;
            ch_ok_q    <= '0;
            ch_data_q  <= 8'h00;
            ch_ovf_q   <= '0;
            rom_addr_q <= '0;
            rom_cs_q   <= 1'b0;
            tmo_err_q  <= 1'b0;
            tmo_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            rr_ptr_q   <= rr_ptr_d;
            pending_q  <= pending_d;
            valid_q    <= valid_d;
            ch_ok_q    <= ch_ok_d;
            ch_data_q  <= ch_data_d;
            ch_ovf_q   <= ch_ovf_d;
            rom_addr_q <= rom_addr_d;
            rom_cs_q   <= rom_cs_d;
            tmo_err_q  <= tmo_err_d;
            tmo_cnt_q  <= tmo_cnt_d;
        end
    end

    // Cache payload needs no reset: valid_q gates every use
    always_ff @(posedge clk) begin
        if (cache_we) begin
            tag_q[sel_q]  <= rom_addr_q;
            byte_q[sel_q] <= rom_data;
        end
    end

    assign ch_ok    = ch_ok_q;
    assign ch_data  = ch_data_q;
    assign ch_ovf   = ch_ovf_q;
    assign rom_addr = rom_addr_q;
    assign rom_cs   = rom_cs_q;
    assign tmo_err  = tmo_err_q;

endmodule
